// File: rtl/spi_gen_pkg.sv
// Shared types, mode constants and the effective bit-count helper for the
// generic SPI master.
package spi_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TRAIL = 2'd3
    } state_e;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int eff_nbits(input int nb, input int dw);
        return ((nb == 0) || (nb > dw)) ? dw : nb;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period tick generator: one-cycle tick every clkdiv+1 enabled cycles,
// with a synchronous restart that zeroes the phase.
module spi_clkgen #(
    parameter int DIVW = 8
) (
    input  logic            clkin,
    input  logic            rst,
    input  logic            en_i,
    input  logic            restart_i,
    input  logic [DIVW-1:0] clkdiv_i,
    output logic            tick_o
);

    logic [DIVW-1:0] cnt_q, cnt_d;

    // Equality compare only, so clkdiv = all-ones never needs a wider counter
    assign tick_o = en_i && (cnt_q == clkdiv_i);

    always_comb begin
        cnt_d = cnt_q + DIVW'(1);
        if (restart_i || !en_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clkin) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised SPI master: configurable width, divider, bit order, CPOL/CPHA
// and automatic or manual chip select with a one-cycle done strobe.
//
// state | meaning
// IDLE  | waiting for go; sclk idles, cs follows autocs/csman
// LEAD  | one half-period of cs setup before the first sclk edge
// SHIFT | 2n half-periods; sclk toggles on every tick
// TRAIL | one half-period of cs hold, then done and back to IDLE
module spi_master_gen
    import spi_gen_pkg::*;
#(
    parameter int DW   = 8,
    parameter int DIVW = 8,
    parameter int NBW  = 6
) (
    input  logic            clkin,
    input  logic            rst,
    input  logic            cpol,
    input  logic            cpha,
    input  logic            cspol,
    input  logic            autocs,
    input  logic            csman,
    input  logic            lsbfirst,
    input  logic [DIVW-1:0] clkdiv,
    input  logic [NBW-1:0]  nbits,
    input  logic            go,
    output logic            busy,
    output logic            done,
    input  logic [DW-1:0]   data_i,
    output logic [DW-1:0]   data_o,
    input  logic            miso,
    output logic            mosi,
    output logic            sclk,
    output logic            cs
);

    state_e          state_q;
    logic            busy_q, done_q, mosi_q, sclk_q, cs_q;
    logic [DW-1:0]   data_o_q, tx_q, rx_q;
    logic [1:0]      mode_q;
    logic            lsb_q, autocs_q, lead_q;
    logic [DIVW-1:0] div_q;
    logic [NBW-1:0]  n_q, k_q;

    logic            tick, accept, cpol_w, cpha_w, last_bit;
    logic            tx_cur, tx_nxt, tx_first;
    logic            cs_man, cs_idle, cs_busy;
    logic [NBW-1:0]  n_d, idx_cur, idx_nxt, idx_first;
    logic [DW-1:0]   rx_d;

    // Position in the word of the k-th bit on the wire
    function automatic logic [NBW-1:0] bit_idx(input logic lsb,
                                               input logic [NBW-1:0] n,
                                               input logic [NBW-1:0] k);
        return lsb ? k : (n - k - NBW'(1));
    endfunction

    assign n_d       = NBW'(eff_nbits(int'(nbits), DW));
    assign accept    = (state_q == ST_IDLE) && go;
    assign cpol_w    = (mode_q == MODE2) || (mode_q == MODE3);
    assign cpha_w    = (mode_q != MODE0) && (mode_q != MODE2);
    assign last_bit  = (k_q == n_q - NBW'(1));

    assign idx_cur   = bit_idx(lsb_q, n_q, k_q);
    assign idx_nxt   = bit_idx(lsb_q, n_q, k_q + NBW'(1));
    assign idx_first = bit_idx(lsbfirst, n_d, '0);
    assign tx_cur    = |(tx_q & (DW'(1) << idx_cur));
    assign tx_nxt    = |(tx_q & (DW'(1) << idx_nxt));
    assign tx_first  = |(data_i & (DW'(1) << idx_first));
    assign rx_d      = rx_q | (DW'(miso) << idx_cur);

    assign cs_man    = csman ? ~cspol : cspol;
    assign cs_idle   = autocs ? cspol : cs_man;
    assign cs_busy   = autocs_q ? ~cspol : cs_man;

    spi_clkgen #(
        .DIVW (DIVW)
    ) u_clkgen (
        .clkin     (clkin),
        .rst       (rst),
        .en_i      (busy_q),
        .restart_i (accept),
        .clkdiv_i  (div_q),
        .tick_o    (tick)
    );

    always_ff @(posedge clkin) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data_o_q <= '0;
            mosi_q   <= 1'b0;
            sclk_q   <= cpol;
            cs_q     <= cspol;
            mode_q   <= MODE0;
            lsb_q    <= 1'b0;
            autocs_q <= 1'b1;
            div_q    <= '0;
            n_q      <= '0;
            k_q      <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            lead_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sclk_q <= cpol;
                    cs_q   <= cs_idle;
                    if (go) begin
                        mode_q   <= {cpol, cpha};
                        lsb_q    <= lsbfirst;
                        div_q    <= clkdiv;
                        n_q      <= n_d;
                        tx_q     <= data_i;
                        autocs_q <= autocs;
                        rx_q     <= '0;
                        k_q      <= '0;
                        lead_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_LEAD;
                        if (autocs) begin
                            cs_q <= ~cspol;
                        end
                        if (!cpha) begin
                            mosi_q <= tx_first;
                        end
                    end
                end
                ST_LEAD: begin
                    sclk_q <= cpol_w;
                    cs_q   <= cs_busy;
                    if (tick) begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    cs_q <= cs_busy;
                    if (tick) begin
                        sclk_q <= ~sclk_q;
                        lead_q <= ~lead_q;
                        if (lead_q) begin
                            if (cpha_w) begin
                                mosi_q <= tx_cur;
                            end else begin
                                rx_q <= rx_d;
                            end
                        end else begin
                            if (cpha_w) begin
                                rx_q <= rx_d;
                            end else if (!last_bit) begin
                                mosi_q <= tx_nxt;
                            end
                            if (last_bit) begin
                                state_q <= ST_TRAIL;
                            end else begin
                                k_q <= k_q + NBW'(1);
                            end
                        end
                    end
                end
                ST_TRAIL: begin
                    sclk_q <= cpol_w;
                    cs_q   <= cs_busy;
                    if (tick) begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        data_o_q <= rx_q;
                        if (autocs_q) begin
                            cs_q <= cspol;
                        end
                    end
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign data_o = data_o_q;
    assign mosi   = mosi_q;
    assign sclk   = sclk_q;
    assign cs     = cs_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Scenario bench for spi_master_gen: per-feature tasks, expected transfers
// queued at stimulus time and popped when done fires.
module tb_spi_master_gen;

    localparam int DW   = 8;
    localparam int DIVW = 8;
    localparam int NBW  = 6;

    logic            clkin = 1'b0;
    logic            rst, cpol, cpha, cspol, autocs, csman, lsbfirst, go;
    logic            miso_drv, loop_en;
    logic [DIVW-1:0] clkdiv;
    logic [NBW-1:0]  nbits;
    logic [DW-1:0]   data_i;
    logic            busy, done, mosi, sclk, cs, miso;
    logic [DW-1:0]   data_o;

    assign miso = loop_en ? mosi : miso_drv;

    always #5 clkin = ~clkin;

    spi_master_gen #(
        .DW   (DW),
        .DIVW (DIVW),
        .NBW  (NBW)
    ) dut (
        .clkin    (clkin),
        .rst      (rst),
        .cpol     (cpol),
        .cpha     (cpha),
        .cspol    (cspol),
        .autocs   (autocs),
        .csman    (csman),
        .lsbfirst (lsbfirst),
        .clkdiv   (clkdiv),
        .nbits    (nbits),
        .go       (go),
        .busy     (busy),
        .done     (done),
        .data_i   (data_i),
        .data_o   (data_o),
        .miso     (miso),
        .mosi     (mosi),
        .sclk     (sclk),
        .cs       (cs)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            lat;
        logic [DW-1:0] seq;
        int            nb;
    } exp_t;

    exp_t sb[$];
    logic mosi_bits[$];
    logic miso_seq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0, accept_cyc = 0, done_cyc = 0, done_cnt = 0;
    int mosi_bad = 0, cs_bad = 0, last_rise = -1, sclk_period = 0;
    logic sclk_p = 1'b0, mosi_p = 1'b0, busy_p = 1'b0;

    // Pin monitor: edge bookkeeping, mosi capture at sample edges, miso slave
    always @(negedge clkin) begin
        cyc++;
        if (busy === 1'b1 && busy_p !== 1'b1) accept_cyc = cyc;
        if (done === 1'b1) begin
            done_cyc = cyc;
            done_cnt++;
        end
        if (busy === 1'b1 && cs !== ~cspol) cs_bad++;
        if (busy === 1'b1 && sclk !== sclk_p) begin
            if ((sclk != cpol) ^ cpha) mosi_bits.push_back(mosi);
            if (((sclk != cpol) == cpha) && miso_seq.size() > 0) miso_drv = miso_seq.pop_front();
            if (sclk === 1'b1) begin
                if (last_rise >= 0) sclk_period = cyc - last_rise;
                last_rise = cyc;
            end
        end
        if (mosi !== mosi_p && !(sclk_p === 1'b1 && sclk === 1'b0)) mosi_bad++;
        sclk_p = sclk;
        mosi_p = mosi;
        busy_p = busy;
    end

    function automatic logic [DW-1:0] order_word(input logic [DW-1:0] d, input int n, input bit lsb);
        logic [DW-1:0] w = '0;
        for (int k = 0; k < n; k++) w = {w[DW-2:0], (lsb ? d[k] : d[n-1-k])};
        return w;
    endfunction

    function automatic logic [DW-1:0] pack_bits();
        logic [DW-1:0] w = '0;
        foreach (mosi_bits[i]) w = {w[DW-2:0], mosi_bits[i]};
        return w;
    endfunction

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clkin);
            #1;
        end
    endtask

    task automatic go_and_wait(output int lat, output bit to);
        int n0, t;
        n0 = done_cnt;
        go = 1'b1;
        tick_n(1);
        go = 1'b0;
        t = 0;
        while (done_cnt == n0 && t < 5000) begin
            tick_n(1);
            t++;
        end
        to  = (done_cnt == n0);
        lat = done_cyc - accept_cyc;
    endtask

    task automatic test_reset();
        rst = 1'b0; cpol = 1'b0; cpha = 1'b0; cspol = 1'b1; autocs = 1'b1; csman = 1'b0;
        lsbfirst = 1'b0; clkdiv = '0; nbits = 6'd8; go = 1'b0; data_i = '0;
        miso_drv = 1'b0; loop_en = 1'b0;
        tick_n(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data_o got %h want 00", data_o); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk); end
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs got %b want 1", cs); end
        rst = 1'b1;
        tick_n(2);
    endtask

    task automatic test_mode0_loop();
        exp_t e; int lat; bit to;
        cpol = 1'b0; cpha = 1'b0; cspol = 1'b1; autocs = 1'b1; lsbfirst = 1'b0;
        clkdiv = 8'd0; nbits = 6'd8; data_i = 8'hA5; loop_en = 1'b1;
        tick_n(2);
        mosi_bits.delete(); cs_bad = 0;
        sb.push_back('{data: 8'hA5, lat: (2*8+2)*1, seq: order_word(8'hA5, 8, 1'b0), nb: 8});
        go_and_wait(lat, to);
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL m0_timeout got no done want done"); end
        checks++; if (data_o !== e.data) begin errors++; $display("FAIL m0_data_o got %h want %h", data_o, e.data); end
        checks++; if (lat != e.lat) begin errors++; $display("FAIL m0_latency got %0d want %0d", lat, e.lat); end
        checks++; if (mosi_bits.size() != e.nb || pack_bits() !== e.seq)
            begin errors++; $display("FAIL m0_mosi_seq got %0d bits %b want %0d bits %b", mosi_bits.size(), pack_bits(), e.nb, e.seq); end
        checks++; if (cs_bad != 0) begin errors++; $display("FAIL m0_cs_active got %0d bad cycles want 0", cs_bad); end
    endtask

    task automatic test_mode3();
        exp_t e; int lat; bit to;
        cpol = 1'b1; cpha = 1'b1; clkdiv = 8'd3; nbits = 6'd8; data_i = 8'h3C;
        loop_en = 1'b0; miso_drv = 1'b0; miso_seq.delete();
        tick_n(3);
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL m3_idle_sclk got %b want 1", sclk); end
        mosi_bad = 0; last_rise = -1; sclk_period = 0; mosi_bits.delete();
        sb.push_back('{data: 8'h00, lat: (2*8+2)*4, seq: order_word(8'h3C, 8, 1'b0), nb: 8});
        go_and_wait(lat, to);
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL m3_timeout got no done want done"); end
        checks++; if (data_o !== e.data) begin errors++; $display("FAIL m3_data_o got %h want %h", data_o, e.data); end
        checks++; if (lat != e.lat) begin errors++; $display("FAIL m3_latency got %0d want %0d", lat, e.lat); end
        checks++; if (sclk_period != 8) begin errors++; $display("FAIL m3_sclk_period got %0d want 8", sclk_period); end
        checks++; if (mosi_bad != 0) begin errors++; $display("FAIL m3_mosi_edge got %0d off-edge changes want 0", mosi_bad); end
        checks++; if (mosi_bits.size() != e.nb || pack_bits() !== e.seq)
            begin errors++; $display("FAIL m3_mosi_seq got %b want %b", pack_bits(), e.seq); end
    endtask

    task automatic test_lsb_short();
        exp_t e; int lat; bit to;
        cpol = 1'b0; cpha = 1'b0; lsbfirst = 1'b1; clkdiv = 8'd0; nbits = 6'd5; data_i = 8'h13;
        loop_en = 1'b0; miso_drv = 1'b1;
        miso_seq.delete();
        repeat (4) miso_seq.push_back(1'b0);
        tick_n(3);
        mosi_bits.delete();
        sb.push_back('{data: 8'h01, lat: (2*5+2)*1, seq: order_word(8'h13, 5, 1'b1), nb: 5});
        go_and_wait(lat, to);
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL lsb_timeout got no done want done"); end
        checks++; if (data_o !== e.data) begin errors++; $display("FAIL lsb_data_o got %h want %h", data_o, e.data); end
        checks++; if (lat != e.lat) begin errors++; $display("FAIL lsb_latency got %0d want %0d", lat, e.lat); end
        checks++; if (mosi_bits.size() != e.nb || pack_bits() !== e.seq)
            begin errors++; $display("FAIL lsb_mosi_seq got %0d bits %b want %0d bits %b", mosi_bits.size(), pack_bits(), e.nb, e.seq); end
        lsbfirst = 1'b0;
    endtask

    task automatic test_go_ignored();
        exp_t e; int lat, n0, t;
        cpol = 1'b0; cpha = 1'b0; clkdiv = 8'd1; nbits = 6'd8; data_i = 8'hC3; loop_en = 1'b1;
        tick_n(2);
        mosi_bits.delete();
        sb.push_back('{data: 8'hC3, lat: (2*8+2)*2, seq: order_word(8'hC3, 8, 1'b0), nb: 8});
        n0 = done_cnt;
        go = 1'b1; tick_n(1); go = 1'b0;
        tick_n(10);
        data_i = 8'h0F; nbits = 6'd4; go = 1'b1;
        tick_n(2);
        go = 1'b0;
        t = 0;
        while (done_cnt == n0 && t < 2000) begin tick_n(1); t++; end
        lat = done_cyc - accept_cyc;
        tick_n(60);
        e = sb.pop_front();
        checks++; if (done_cnt - n0 != 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", done_cnt - n0); end
        checks++; if (data_o !== e.data) begin errors++; $display("FAIL ign_data_o got %h want %h", data_o, e.data); end
        checks++; if (lat != e.lat) begin errors++; $display("FAIL ign_latency got %0d want %0d", lat, e.lat); end
        checks++; if (mosi_bits.size() != e.nb || pack_bits() !== e.seq)
            begin errors++; $display("FAIL ign_mosi_seq got %b want %b", pack_bits(), e.seq); end
    endtask

    task automatic test_reset_abort();
        int n0;
        cpol = 1'b1; cpha = 1'b1; cspol = 1'b1; autocs = 1'b1; clkdiv = 8'd3;
        nbits = 6'd8; data_i = 8'h81; loop_en = 1'b0; miso_drv = 1'b1;
        tick_n(3);
        n0 = done_cnt;
        go = 1'b1; tick_n(1); go = 1'b0;
        tick_n(9);
        rst = 1'b0;
        tick_n(1);
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL abort_sclk got %b want 1", sclk); end
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL abort_cs got %b want 1", cs); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL abort_data_o got %h want 00", data_o); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL abort_mosi got %b want 0", mosi); end
        rst = 1'b1;
        tick_n(150);
        checks++; if (done_cnt != n0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", done_cnt - n0); end
    endtask

    task automatic test_div_max();
        exp_t e; int lat; bit to;
        cpol = 1'b0; cpha = 1'b0; clkdiv = 8'hFF; nbits = 6'd1; data_i = 8'h01;
        loop_en = 1'b0; miso_drv = 1'b1; miso_seq.delete();
        tick_n(3);
        mosi_bits.delete();
        sb.push_back('{data: 8'h01, lat: (2*1+2)*256, seq: order_word(8'h01, 1, 1'b0), nb: 1});
        go_and_wait(lat, to);
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL divmax_timeout got no done want done"); end
        checks++; if (data_o !== e.data) begin errors++; $display("FAIL divmax_data_o got %h want %h", data_o, e.data); end
        checks++; if (lat != e.lat) begin errors++; $display("FAIL divmax_latency got %0d want %0d", lat, e.lat); end
        checks++; if (mosi_bits.size() != e.nb || pack_bits() !== e.seq)
            begin errors++; $display("FAIL divmax_mosi_seq got %b want %b", pack_bits(), e.seq); end
    endtask

    task automatic test_manual_cs_back_to_back();
        exp_t e; int n0, t, d1, lat;
        cpol = 1'b0; cpha = 1'b0; cspol = 1'b1; autocs = 1'b0; clkdiv = 8'd0;
        nbits = 6'd0; data_i = 8'h5A; loop_en = 1'b1;
        csman = 1'b1; tick_n(2);
        checks++; if (cs !== 1'b0) begin errors++; $display("FAIL man_cs_on got %b want 0", cs); end
        csman = 1'b0; tick_n(2);
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL man_cs_off got %b want 1", cs); end
        csman = 1'b1; tick_n(2);
        cs_bad = 0; mosi_bits.delete();
        sb.push_back('{data: 8'h5A, lat: 18, seq: order_word(8'h5A, 8, 1'b0), nb: 8});
        sb.push_back('{data: 8'h96, lat: 18, seq: order_word(8'h96, 8, 1'b0), nb: 8});
        n0 = done_cnt;
        go = 1'b1;
        t = 0;
        while (done_cnt == n0 && t < 500) begin tick_n(1); t++; end
        data_i = 8'h96;
        d1 = done_cyc;
        lat = done_cyc - accept_cyc;
        e = sb.pop_front();
        checks++; if (data_o !== e.data) begin errors++; $display("FAIL b2b_first_data got %h want %h", data_o, e.data); end
        checks++; if (lat != e.lat) begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", lat, e.lat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_in_done got %b want 0", busy); end
        t = 0;
        while (done_cnt == n0 + 1 && t < 500) begin tick_n(1); t++; end
        go = 1'b0;
        lat = done_cyc - accept_cyc;
        e = sb.pop_front();
        checks++; if (accept_cyc - d1 != 1) begin errors++; $display("FAIL b2b_gap got %0d cycles want 1", accept_cyc - d1); end
        checks++; if (data_o !== e.data) begin errors++; $display("FAIL b2b_second_data got %h want %h", data_o, e.data); end
        checks++; if (lat != e.lat) begin errors++; $display("FAIL b2b_second_latency got %0d want %0d", lat, e.lat); end
        tick_n(30);
        checks++; if (done_cnt - n0 != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt - n0); end
        checks++; if (cs_bad != 0) begin errors++; $display("FAIL b2b_manual_cs got %0d bad cycles want 0", cs_bad); end
        checks++; if (mosi_bits.size() != 16) begin errors++; $display("FAIL b2b_bit_count got %0d want 16", mosi_bits.size()); end
        autocs = 1'b1;
    endtask

    initial begin
        test_reset();
        test_mode0_loop();
        test_mode3();
        test_lsb_short();
        test_go_ignored();
        test_reset_abort();
        test_div_max();
        test_manual_cs_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
